// File: rtl/morse_keyer.sv
// Morse keyer: sends one character of dot/dash elements with standard unit timing.
// Optional sidetone square wave is built when MORSE_KEYER_SIDETONE_EN is defined.
module morse_keyer #(
   parameter int UNIT_CYCLES      = 1000,
   parameter int TONE_HALF_CYCLES = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sym_valid,
   output logic        sym_ready,
   input  logic [11:0] symbol_data,
   input  logic [2:0]  symbol_count,
   input  logic        word_gap,
   input  logic        abort,
   output logic        key_out,
   output logic        tone_out,
   output logic        done,
   output logic        bad_elem
);

   localparam int CNT_W = $clog2(7 * UNIT_CYCLES + 1);

   localparam logic [CNT_W-1:0] C_UNIT  = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_THREE = CNT_W'(3 * UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_SEVEN = CNT_W'(7 * UNIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MARK,
      S_SPACE,
      S_GAP
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [11:0]      r_data;
   logic [2:0]       r_idx;
   logic             r_wgap;
   logic             r_bad;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [11:0]      w_data_nxt;
   logic [2:0]       w_idx_nxt;
   logic             w_wgap_nxt;
   logic [2:0]       w_count_clamped;
   logic [2:0]       w_idx_first;
   logic [2:0]       w_idx_dec;
   logic [1:0]       w_code_first;
   logic [1:0]       w_code_dec;
   logic [1:0]       w_code_cur;
   logic [1:0]       w_code_nxt;
   logic             w_mark_enter;

   function automatic logic is_legal(input logic [1:0] code);
      return (code == 2'b01) || (code == 2'b10);
   endfunction

   // Dashes last three units; dots and illegal codes last one.
   function automatic logic [CNT_W-1:0] mark_len(input logic [1:0] code);
      return (code == 2'b10) ? C_THREE : C_UNIT;
   endfunction

   assign w_count_clamped = (symbol_count > 3'd6) ? 3'd6 : symbol_count;
   assign w_idx_first     = w_count_clamped - 3'd1;
   assign w_idx_dec       = r_idx - 3'd1;
   assign w_code_first    = 2'(symbol_data >> {w_idx_first, 1'b0});
   assign w_code_dec      = 2'(r_data >> {w_idx_dec, 1'b0});
   assign w_code_cur      = 2'(r_data >> {r_idx, 1'b0});
   assign w_code_nxt      = 2'(w_data_nxt >> {w_idx_nxt, 1'b0});
   assign w_mark_enter    = (w_state_nxt == S_MARK) && (r_state != S_MARK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_idx   <= '0;
         r_wgap  <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_idx   <= w_idx_nxt;
         r_wgap  <= w_wgap_nxt;
         r_bad   <= w_mark_enter && !is_legal(w_code_nxt);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_idx_nxt   = r_idx;
      w_wgap_nxt  = r_wgap;
      sym_ready   = (r_state == S_IDLE);
      key_out     = (r_state == S_MARK) && is_legal(w_code_cur);
      done        = (r_state == S_GAP) && (r_cnt == '0) && !abort;
      bad_elem    = r_bad;

      if (abort) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sym_valid) begin
                  w_data_nxt = symbol_data;
                  w_wgap_nxt = word_gap;
                  if (w_count_clamped == 3'd0) begin
                     w_state_nxt = S_GAP;
                     w_idx_nxt   = 3'd0;
                     w_cnt_nxt   = word_gap ? C_SEVEN : C_THREE;
                  end else begin
                     w_state_nxt = S_MARK;
                     w_idx_nxt   = w_idx_first;
                     w_cnt_nxt   = mark_len(w_code_first);
                  end
               end
            end
            S_MARK: begin
               if (r_cnt == '0) begin
                  if (r_idx == 3'd0) begin
                     w_state_nxt = S_GAP;
                     w_cnt_nxt   = r_wgap ? C_SEVEN : C_THREE;
                  end else begin
                     w_state_nxt = S_SPACE;
                     w_cnt_nxt   = C_UNIT;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            S_SPACE: begin
               if (r_cnt == '0) begin
                  w_state_nxt = S_MARK;
                  w_idx_nxt   = w_idx_dec;
                  w_cnt_nxt   = mark_len(w_code_dec);
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (r_cnt == '0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

`ifdef MORSE_KEYER_SIDETONE_EN
   localparam int TONE_W = $clog2(TONE_HALF_CYCLES + 1);

   logic [TONE_W-1:0] r_tone_cnt;
   logic              r_tone;
   logic              w_key_nxt;

   assign w_key_nxt = (w_state_nxt == S_MARK) && is_legal(w_code_nxt);

   // Phase restarts high at every keyed mark so each mark sounds identical.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tone     <= 1'b0;
         r_tone_cnt <= '0;
      end else if (w_mark_enter && w_key_nxt) begin
         r_tone     <= 1'b1;
         r_tone_cnt <= TONE_W'(TONE_HALF_CYCLES - 1);
      end else if (w_key_nxt) begin
         if (r_tone_cnt == '0) begin
            r_tone     <= ~r_tone;
            r_tone_cnt <= TONE_W'(TONE_HALF_CYCLES - 1);
         end else begin
            r_tone_cnt <= r_tone_cnt - 1'b1;
         end
      end else begin
         r_tone     <= 1'b0;
         r_tone_cnt <= '0;
      end
   end

   assign tone_out = r_tone;
`else
   assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: directed letters, boundaries, abort, reset,
// then random characters against a timeline model built from Morse timing rules.
module tb_morse_keyer;

   localparam int U = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sym_valid = 1'b0;
   logic        sym_ready;
   logic [11:0] symbol_data = '0;
   logic [2:0]  symbol_count = '0;
   logic        word_gap = 1'b0;
   logic        abort = 1'b0;
   logic        key_out;
   logic        tone_out;
   logic        done;
   logic        bad_elem;

   int n_cmp = 0;
   int n_mis = 0;

   bit q_key[$];
   bit q_done[$];
   bit q_bad[$];
   bit q_tone[$];

   morse_keyer #(
      .UNIT_CYCLES     (U),
      .TONE_HALF_CYCLES(H)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sym_valid   (sym_valid),
      .sym_ready   (sym_ready),
      .symbol_data (symbol_data),
      .symbol_count(symbol_count),
      .word_gap    (word_gap),
      .abort       (abort),
      .key_out     (key_out),
      .tone_out    (tone_out),
      .done        (done),
      .bad_elem    (bad_elem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected per-cycle timeline of one character, starting the cycle after accept.
   task automatic build(input logic [11:0] d, input int cnt, input bit wg);
      int c;
      q_key.delete(); q_done.delete(); q_bad.delete(); q_tone.delete();
      c = (cnt > 6) ? 6 : cnt;
      for (int i = c - 1; i >= 0; i--) begin
         int  code;
         int  len;
         bit  legal;
         code  = int'((d >> (2 * i)) & 12'h3);
         legal = (code == 1) || (code == 2);
         len   = (code == 2) ? 3 * U : U;
         for (int j = 0; j < len; j++) begin
            q_key.push_back(legal);
            q_bad.push_back(!legal && (j == 0));
            q_done.push_back(1'b0);
            q_tone.push_back(legal && (((j / H) % 2) == 0));
         end
         if (i > 0) begin
            for (int j = 0; j < U; j++) begin
               q_key.push_back(1'b0); q_bad.push_back(1'b0);
               q_done.push_back(1'b0); q_tone.push_back(1'b0);
            end
         end
      end
      for (int j = 0; j < (wg ? 7 * U : 3 * U); j++) begin
         q_key.push_back(1'b0); q_bad.push_back(1'b0); q_tone.push_back(1'b0);
         q_done.push_back(j == (wg ? 7 * U : 3 * U) - 1);
      end
   endtask

   // Called at a negedge while the keyer is idle; returns just after the accepting edge.
   task automatic send(input logic [11:0] d, input logic [2:0] cnt, input bit wg);
      symbol_data  = d;
      symbol_count = cnt;
      word_gap     = wg;
      sym_valid    = 1'b1;
      @(posedge clk);
      #1;
      sym_valid    = 1'b0;
      symbol_data  = 12'($urandom);
      symbol_count = 3'($urandom);
      word_gap     = 1'($urandom);
   endtask

   task automatic check_wave(input string nm, output int nbad);
      bit exp_tone;
      nbad = 0;
      for (int k = 0; k < q_key.size(); k++) begin
         @(negedge clk);
`ifdef MORSE_KEYER_SIDETONE_EN
         exp_tone = q_tone[k];
`else
         exp_tone = 1'b0;
`endif
         chk({nm, "_key"},   key_out,   q_key[k]);
         chk({nm, "_done"},  done,      q_done[k]);
         chk({nm, "_bad"},   bad_elem,  q_bad[k]);
         chk({nm, "_ready"}, sym_ready, 1'b0);
         chk({nm, "_tone"},  tone_out,  exp_tone);
         if (bad_elem === 1'b1) nbad++;
      end
      @(negedge clk);
      chk({nm, "_ready_after"}, sym_ready, 1'b1);
      chk({nm, "_key_after"},   key_out,   1'b0);
      chk({nm, "_done_after"},  done,      1'b0);
   endtask

   initial begin
      int nb;
      logic [11:0] rd;
      logic [2:0]  rc;
      bit          rw;

      #12;
      chk("rst_key",   key_out,   1'b0);
      chk("rst_tone",  tone_out,  1'b0);
      chk("rst_done",  done,      1'b0);
      chk("rst_bad",   bad_elem,  1'b0);
      chk("rst_ready", sym_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", sym_ready, 1'b1);

      build(12'h006, 2, 1'b0); send(12'h006, 3'd2, 1'b0); check_wave("A", nb);
      build(12'h001, 1, 1'b1); send(12'h001, 3'd1, 1'b1); check_wave("E_word", nb);
      build(12'h00C, 2, 1'b0); send(12'h00C, 3'd2, 1'b0); check_wave("ill00C", nb);
      chk("ill00C_nbad", nb, 2);
      build(12'h00D, 2, 1'b0); send(12'h00D, 3'd2, 1'b0); check_wave("ill00D", nb);
      chk("ill00D_nbad", nb, 1);
      build(12'hABC, 0, 1'b0); send(12'hABC, 3'd0, 1'b0); check_wave("cnt0", nb);
      build(12'hFFF, 7, 1'b0); send(12'hFFF, 3'd7, 1'b0); check_wave("cnt7", nb);
      chk("cnt7_nbad", nb, 6);
      build(12'h02A, 3, 1'b0); send(12'h02A, 3'd3, 1'b0); check_wave("O_tone", nb);

      // Abort mid-dash while a new character is already offered.
      send(12'h002, 3'd1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort_pre_key", key_out, 1'b1);
      end
      abort        = 1'b1;
      sym_valid    = 1'b1;
      symbol_data  = 12'h001;
      symbol_count = 3'd1;
      word_gap     = 1'b0;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_key",   key_out,   1'b0);
      chk("abort_ready", sym_ready, 1'b1);
      chk("abort_done",  done,      1'b0);
      build(12'h001, 1, 1'b0);
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
      check_wave("post_abort", nb);

      // Asynchronous reset in the middle of a mark.
      send(12'h006, 3'd2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_pre_key", key_out, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_key",   key_out,   1'b0);
      chk("mid_rst_tone",  tone_out,  1'b0);
      chk("mid_rst_ready", sym_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("mid_post_done",  done,      1'b0);
         chk("mid_post_key",   key_out,   1'b0);
         chk("mid_post_ready", sym_ready, 1'b1);
      end

      for (int r = 0; r < 10; r++) begin
         rd = 12'($urandom);
         rc = 3'($urandom_range(0, 7));
         rw = 1'($urandom_range(0, 1));
         build(rd, int'(rc), rw);
         send(rd, rc, rw);
         check_wave("rand", nb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
